uart_tx: RTL and testbench

- Transmit-only UART serializer: accepts one byte on a single-cycle start strobe and emits an 8N1 asynchronous serial frame (start, 8 data LSB-first, stop) on tx.
- Sits between a byte-producing controller and the board pin.
- Reports occupancy on tx_busy so upstream logic waits before issuing the next byte.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_tx.sv | 133 +++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_tx serializer.
//   - state_t            : transmitter FSM encoding
//   - DATA_BITS          : payload width of one frame
//   - IDLE_LEVEL         : mark level driven on the line between frames
//   - calc_clks_per_bit  : clock cycles per serial bit, integer floor
// Optional build macro: UART_TX_PARITY_EN adds a PARITY state to the encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                      input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter for the UART transmitter.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   clear    - holds the counter at zero (asserted while the FSM is idle)
//   bit_done - one-cycle tick on the last cycle of each serial bit
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned      CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: transmit-only 8N1 UART serializer.
// A byte is accepted on a single-cycle tx_start while idle and shifted out
// LSB first as start, 8 data bits, stop; tx_busy covers the whole frame.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   tx_start - request strobe, sampled only while idle
//   tx_data  - byte to send, captured on the accepting edge
//   tx       - serial line (idles high), registered
//   tx_busy  - frame in progress, registered
// Optional build macro: UART_TX_PARITY_EN inserts a parity bit before stop
// (parameter PARITY_ODD selects odd parity, default even).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD_RATE    = 9600,
`ifdef UART_TX_PARITY_EN
    parameter bit          PARITY_ODD   = 1'b0,
`endif
    parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int unsigned          IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_done;

    // Counter held at zero while idle so the start bit gets a full period.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == IDLE),
        .bit_done (bit_done)
    );

    // State register (also holds the registered outputs).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic decodes the *next* state so tx/tx_busy can be registered
    // without adding a cycle of latency behind the FSM.
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = (state_d != IDLE);
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = PARITY_ODD ? ~(^shift_d) : (^shift_d);
`endif
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two instances share one clock: u_a at default parameters (5208 clocks/bit)
// and u_b with CLKS_PER_BIT=4 for the short-frame scenarios.
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
module tb_uart_tx;

    localparam int unsigned CPB_A = 5208;
    localparam int unsigned CPB_B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       tx_a, tx_b, busy_a, busy_b;

    always #5 clk = ~clk;

    uart_tx u_a (
        .clk      (clk),
        .rst      (rst_a),
        .tx_start (start_a),
        .tx_data  (data_a),
        .tx       (tx_a),
        .tx_busy  (busy_a)
    );

    uart_tx #(
        .CLKS_PER_BIT(CPB_B)
    ) u_b (
        .clk      (clk),
        .rst      (rst_b),
        .tx_start (start_b),
        .tx_data  (data_b),
        .tx       (tx_b),
        .tx_busy  (busy_b)
    );

    bit          sel = 1'b0;
    int unsigned cpb = CPB_A;
    logic        tx_w, busy_w;
    assign tx_w   = sel ? tx_b   : tx_a;
    assign busy_w = sel ? busy_b : busy_a;

    int tests = 0;
    int fails = 0;

    task automatic use_dut(input bit b);
        sel = b;
        cpb = b ? CPB_B : CPB_A;
    endtask

    task automatic drive(input logic s, input logic [7:0] d);
        if (sel) begin
            start_b = s;
            data_b  = d;
        end else begin
            start_a = s;
            data_a  = d;
        end
    endtask

    // Expected line level for each bit slot of a frame, in transmit order.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        f[9] = (ones % 2 == 1);  // even parity: total ones incl. parity is even
`endif
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    // Issue a byte at the current negedge and check the whole frame.
    // hold keeps tx_start high; inject_at >= 0 pulses tx_start with
    // inject_data at that cycle of the frame (must be ignored).
    task automatic run_frame(input logic [7:0] d, input bit hold, input int inject_at,
                             input logic [7:0] inject_data, input string name);
        logic [10:0] f;
        int busy_cnt;
        int match;
        int k;
        f        = model_frame(d);
        busy_cnt = 0;
        k        = 0;
        drive(1'b1, d);
        @(negedge clk);
        if (!hold) drive(1'b0, d);
        tests++;
        if (tx_w !== 1'b0 || busy_w !== 1'b1) begin
            fails++;
            $display("FAIL %s start latency: tx=%b busy=%b, expected tx=0 busy=1", name, tx_w, busy_w);
        end
        for (int b = 0; b < NBITS; b++) begin
            match = 0;
            for (int c = 0; c < int'(cpb); c++) begin
                if (tx_w === f[b]) match++;
                if (busy_w === 1'b1) busy_cnt++;
                if (inject_at >= 0 && k == inject_at) drive(1'b1, inject_data);
                else if (inject_at >= 0 && k == inject_at + 1) drive(1'b0, inject_data);
                k++;
                @(negedge clk);
            end
            tests++;
            if (match != int'(cpb)) begin
                fails++;
                $display("FAIL %s bit%0d: %0d cycles at level %b, expected %0d", name, b, match, f[b], cpb);
            end
        end
        tests++;
        if (busy_cnt != NBITS * int'(cpb)) begin
            fails++;
            $display("FAIL %s busy length: got %0d expected %0d", name, busy_cnt, NBITS * cpb);
        end
        tests++;
        if (tx_w !== 1'b1 || busy_w !== 1'b0) begin
            fails++;
            $display("FAIL %s end idle: tx=%b busy=%b, expected tx=1 busy=0", name, tx_w, busy_w);
        end
    endtask

    task automatic check_idle(input int n, input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < n; i++) begin
            if (tx_w === 1'b1 && busy_w === 1'b0) ok++;
            @(negedge clk);
        end
        tests++;
        if (ok != n) begin
            fails++;
            $display("FAIL %s idle cycles: got %0d expected %0d", name, ok, n);
        end
    endtask

    task automatic test_reset();
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        tests++;
        if ({tx_a, busy_a, tx_b, busy_b} !== 4'b1010) begin
            fails++;
            $display("FAIL reset async: got %b expected 1010", {tx_a, busy_a, tx_b, busy_b});
        end
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        tests++;
        if ({tx_a, busy_a, tx_b, busy_b} !== 4'b1010) begin
            fails++;
            $display("FAIL reset release: got %b expected 1010", {tx_a, busy_a, tx_b, busy_b});
        end
    endtask

    task automatic test_single_default();
        use_dut(1'b0);
        run_frame(8'hA3, 1'b0, -1, 8'h00, "single_a3");
        use_dut(1'b1);
    endtask

    task automatic test_busy_reject();
        use_dut(1'b1);
        run_frame(8'h55, 1'b0, 13, 8'hFF, "busy_reject");
        check_idle(2 * NBITS * CPB_B, "busy_reject");
    endtask

    task automatic test_back_to_back();
        use_dut(1'b1);
        for (int i = 0; i < 3; i++) run_frame(8'h00, 1'b1, -1, 8'h00, "back_to_back");
        drive(1'b0, 8'h00);
        check_idle(6, "back_to_back");
    endtask

    task automatic test_reset_abort();
        use_dut(1'b1);
        drive(1'b1, 8'h0F);
        @(negedge clk);
        drive(1'b0, 8'h0F);
        repeat (15) @(negedge clk);
        tests++;
        if (busy_b !== 1'b1) begin
            fails++;
            $display("FAIL abort pre: busy=%b expected 1", busy_b);
        end
        #1 rst_b = 1'b0;
        #1;
        tests++;
        if (tx_b !== 1'b1 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL abort async: tx=%b busy=%b, expected tx=1 busy=0", tx_b, busy_b);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        check_idle(2, "abort");
        run_frame(8'h0F, 1'b0, -1, 8'h00, "abort_refire");
    endtask

    task automatic test_random();
        logic [7:0] d, junk;
        int inj, gap;
        use_dut(1'b1);
        for (int i = 0; i < 10; i++) begin
            d    = 8'($urandom);
            junk = 8'($urandom);
            inj  = ($urandom % 2 == 0) ? -1 : int'($urandom_range(1, NBITS * CPB_B - 3));
            gap  = int'($urandom_range(0, 4));
            run_frame(d, 1'b0, inj, junk, "random");
            if (gap > 0) check_idle(gap, "random_gap");
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        use_dut(1'b1);
        run_frame(8'h07, 1'b0, -1, 8'h00, "parity_07");
        run_frame(8'h03, 1'b0, -1, 8'h00, "parity_03");
    endtask
`endif

    initial begin
        test_reset();
        test_single_default();
        test_busy_reject();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
